// File: rtl/spatz_spm_partition_ctrl_pkg.sv
// rtl/spatz_spm_partition_ctrl_pkg.sv - shared state encoding and size check for the SPM partition controller
package spatz_partition_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH_REQ,
    FLUSH_WAIT,
    COMMIT
  } part_state_e;

  // Granule must be a power of two so the low bits act as the alignment mask.
  function automatic logic size_is_valid(input logic [31:0] size,
                                         input logic [31:0] granule,
                                         input logic [31:0] l1_size);
    return ((size & (granule - 32'd1)) == 32'd0) && (size <= l1_size);
  endfunction

endpackage

// File: rtl/spatz_spm_partition_ctrl_if.sv
// rtl/spatz_spm_partition_ctrl_if.sv - CSR, core-port observation and cache-flush signals of the partition controller
interface spatz_spm_partition_ctrl_if #(
  parameter int NumIO     = 4,
  parameter int AddrWidth = 32
);
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [AddrWidth-1:0] cfg_spm_size_i;
  logic                 cfg_error_o;
  logic [AddrWidth-1:0] spm_size_o;
  logic                 busy_o;
  logic [NumIO-1:0]     req_valid_i;
  logic [NumIO-1:0]     req_ready_i;
  logic [NumIO-1:0]     rsp_valid_i;
  logic [NumIO-1:0]     gate_o;
  logic                 flush_valid_o;
  logic                 flush_ready_i;
  logic                 flush_done_i;

  modport slave (
    input  cfg_valid_i, cfg_spm_size_i, req_valid_i, req_ready_i, rsp_valid_i,
           flush_ready_i, flush_done_i,
    output cfg_ready_o, cfg_error_o, spm_size_o, busy_o, gate_o, flush_valid_o
  );

  modport master (
    output cfg_valid_i, cfg_spm_size_i, req_valid_i, req_ready_i, rsp_valid_i,
           flush_ready_i, flush_done_i,
    input  cfg_ready_o, cfg_error_o, spm_size_o, busy_o, gate_o, flush_valid_o
  );
endinterface

// File: rtl/spatz_spm_partition_ctrl_cnt.sv
// rtl/spatz_spm_partition_ctrl_cnt.sv - per-port outstanding request counter with full/zero flags
module spatz_outstanding_cnt #(
  parameter int MaxOutstanding = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_zero
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign o_full = (r_cnt == CntW'(MaxOutstanding));
  assign o_zero = (r_cnt == '0);

  // A response with nothing outstanding means the observed port is broken.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_dec && !i_inc && (r_cnt == '0)));

endmodule

// File: rtl/spatz_spm_partition_ctrl.sv
// rtl/spatz_spm_partition_ctrl.sv - validates a new SPM size, drains and gates core traffic,
// flushes the L1 cache, then commits the size to the address mapper.
module spatz_spm_partition_ctrl
  import spatz_partition_pkg::*;
#(
  parameter int                   NumIO          = 4,
  parameter int                   AddrWidth      = 32,
  parameter logic [AddrWidth-1:0] L1Size         = 32'h0002_0000,
  parameter logic [AddrWidth-1:0] Granule        = 32'h0000_1000,
  parameter logic [AddrWidth-1:0] DefaultSpmSize = 32'h0001_0000,
  parameter int                   MaxOutstanding = 8
) (
  input logic clk_i,
  input logic rst_i,
  spatz_spm_partition_ctrl_if.slave bus
);

  part_state_e          r_state;
  logic [AddrWidth-1:0] r_pending;
  logic [AddrWidth-1:0] r_spm;
  logic                 r_err;

  logic [NumIO-1:0]     w_full;
  logic [NumIO-1:0]     w_zero;
  logic                 w_cfg_hs;
  logic                 w_size_ok;
  logic                 w_busy;

  for (genvar j = 0; j < NumIO; j++) begin : g_cnt
    spatz_outstanding_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_inc (bus.req_valid_i[j] & bus.req_ready_i[j]),
      .i_dec (bus.rsp_valid_i[j]),
      .o_full(w_full[j]),
      .o_zero(w_zero[j])
    );
  end

  assign w_cfg_hs  = bus.cfg_valid_i && (r_state == IDLE);
  assign w_size_ok = size_is_valid(32'(bus.cfg_spm_size_i), 32'(Granule), 32'(L1Size));
  assign w_busy    = (r_state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= DefaultSpmSize;
      r_spm     <= DefaultSpmSize;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_cfg_hs) begin
            if (!w_size_ok) begin
              r_err <= 1'b1;
            end else if (bus.cfg_spm_size_i != r_spm) begin
              r_pending <= bus.cfg_spm_size_i;
              r_state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (&w_zero) r_state <= FLUSH_REQ;
        end
        FLUSH_REQ: begin
          // A completion that arrives with the acceptance skips the wait state.
          if (bus.flush_ready_i) begin
            r_state <= bus.flush_done_i ? COMMIT : FLUSH_WAIT;
          end
        end
        FLUSH_WAIT: begin
          if (bus.flush_done_i) r_state <= COMMIT;
        end
        COMMIT: begin
          r_spm   <= r_pending;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready_o   = (r_state == IDLE);
  assign bus.cfg_error_o   = r_err;
  assign bus.spm_size_o    = r_spm;
  assign bus.busy_o        = w_busy;
  assign bus.gate_o        = {NumIO{w_busy}} | w_full;
  assign bus.flush_valid_o = (r_state == FLUSH_REQ);

endmodule

// File: tb/tb_spatz_spm_partition_ctrl.sv
// tb/tb_spatz_spm_partition_ctrl.sv - directed bench for the SPM partition controller
module tb_spatz_spm_partition_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spatz_spm_partition_ctrl_if #(.NumIO(4), .AddrWidth(32)) bus ();

  spatz_spm_partition_ctrl dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] size;
    logic        exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush(input int budget, output int cycles);
    cycles = 0;
    while (bus.flush_valid_o !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic request(input logic [31:0] size);
    bus.cfg_valid_i    = 1'b1;
    bus.cfg_spm_size_i = size;
    tick();
    bus.cfg_valid_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;

    vecs[0] = '{"misaligned_0x1800",  32'h0000_1800, 1'b1};
    vecs[1] = '{"too_large_0x21000",  32'h0002_1000, 1'b1};
    vecs[2] = '{"same_size_noop",     32'h0001_0000, 1'b0};
    vecs[3] = '{"misaligned_0x1",     32'h0000_0001, 1'b1};
    vecs[4] = '{"huge_aligned",       32'hFFFF_F000, 1'b1};
    vecs[5] = '{"misaligned_0x20800", 32'h0002_0800, 1'b1};

    bus.cfg_valid_i    = 1'b0;
    bus.cfg_spm_size_i = '0;
    bus.req_valid_i    = '0;
    bus.req_ready_i    = '0;
    bus.rsp_valid_i    = '0;
    bus.flush_ready_i  = 1'b0;
    bus.flush_done_i   = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("reset_spm_size", bus.spm_size_o, 32'h0001_0000);
    check("reset_gate", bus.gate_o, 4'h0);
    check("reset_busy", bus.busy_o, 1'b0);
    check("reset_cfg_ready", bus.cfg_ready_o, 1'b1);
    check("reset_flush_valid", bus.flush_valid_o, 1'b0);
    check("reset_cfg_error", bus.cfg_error_o, 1'b0);

    for (int i = 0; i < 6; i++) begin
      request(vecs[i].size);
      check({vecs[i].name, "_err"}, bus.cfg_error_o, vecs[i].exp_err);
      check({vecs[i].name, "_busy"}, bus.busy_o, 1'b0);
      check({vecs[i].name, "_ready"}, bus.cfg_ready_o, 1'b1);
      check({vecs[i].name, "_spm"}, bus.spm_size_o, 32'h0001_0000);
      tick();
      check({vecs[i].name, "_err_pulse"}, bus.cfg_error_o, 1'b0);
    end

    // Best-case grow: cycle-by-cycle walk through every state.
    bus.flush_ready_i = 1'b1;
    request(32'h0000_8000);
    check("grow_c1_busy", bus.busy_o, 1'b1);
    check("grow_c1_gate", bus.gate_o, 4'hF);
    check("grow_c1_flush", bus.flush_valid_o, 1'b0);
    check("grow_c1_ready", bus.cfg_ready_o, 1'b0);
    tick();
    check("grow_c2_flush", bus.flush_valid_o, 1'b1);
    tick();
    check("grow_c3_flush", bus.flush_valid_o, 1'b0);
    check("grow_c3_busy", bus.busy_o, 1'b1);
    bus.flush_done_i = 1'b1;
    tick();
    bus.flush_done_i = 1'b0;
    check("grow_c4_spm_old", bus.spm_size_o, 32'h0001_0000);
    check("grow_c4_busy", bus.busy_o, 1'b1);
    tick();
    check("grow_c5_spm_new", bus.spm_size_o, 32'h0000_8000);
    check("grow_c5_gate", bus.gate_o, 4'h0);
    check("grow_c5_busy", bus.busy_o, 1'b0);

    // Drain ordering: three requests outstanding on port 2.
    bus.req_valid_i[2] = 1'b1;
    bus.req_ready_i[2] = 1'b1;
    repeat (3) tick();
    bus.req_valid_i = '0;
    bus.req_ready_i = '0;
    request(32'h0001_8000);
    for (int k = 0; k < 3; k++) begin
      check("drain_gate", bus.gate_o, 4'hF);
      check("drain_no_flush", bus.flush_valid_o, 1'b0);
      tick();
      bus.rsp_valid_i[2] = 1'b1;
      tick();
      bus.rsp_valid_i[2] = 1'b0;
      check("drain_no_flush_after_rsp", bus.flush_valid_o, 1'b0);
    end
    wait_flush(6, cyc);
    check("drain_release_latency", cyc, 1);
    tick();
    bus.flush_done_i = 1'b1;
    tick();
    bus.flush_done_i = 1'b0;
    tick();
    check("drain_commit_spm", bus.spm_size_o, 32'h0001_8000);
    check("drain_commit_gate", bus.gate_o, 4'h0);

    // Port 0 saturates at eight outstanding.
    bus.req_valid_i[0] = 1'b1;
    bus.req_ready_i[0] = 1'b1;
    repeat (7) tick();
    check("full_at7_gate", bus.gate_o, 4'h0);
    tick();
    check("full_at8_gate", bus.gate_o, 4'h1);
    check("full_at8_busy", bus.busy_o, 1'b0);
    bus.rsp_valid_i[0] = 1'b1;
    tick();
    bus.req_valid_i = '0;
    bus.req_ready_i = '0;
    check("full_simul_gate", bus.gate_o, 4'h1);
    tick();
    bus.rsp_valid_i[0] = 1'b0;
    check("full_dec_gate", bus.gate_o, 4'h0);
    bus.rsp_valid_i[0] = 1'b1;
    repeat (7) tick();
    bus.rsp_valid_i[0] = 1'b0;

    // Flush accepted and completed in the same cycle goes straight to commit.
    bus.flush_ready_i = 1'b0;
    request(32'h0000_0000);
    wait_flush(6, cyc);
    check("samecyc_flush_latency", cyc, 1);
    tick();
    check("samecyc_flush_held", bus.flush_valid_o, 1'b1);
    bus.flush_ready_i = 1'b1;
    bus.flush_done_i  = 1'b1;
    tick();
    bus.flush_done_i  = 1'b0;
    check("samecyc_commit_busy", bus.busy_o, 1'b1);
    check("samecyc_commit_flush", bus.flush_valid_o, 1'b0);
    check("samecyc_commit_spm_old", bus.spm_size_o, 32'h0001_8000);
    tick();
    check("samecyc_spm_zero", bus.spm_size_o, 32'h0000_0000);
    check("samecyc_busy", bus.busy_o, 1'b0);

    // Reset while waiting for the flush to complete.
    request(32'h0000_4000);
    wait_flush(6, cyc);
    check("rst_flush_latency", cyc, 1);
    tick();
    check("rst_in_wait_busy", bus.busy_o, 1'b1);
    check("rst_in_wait_flush", bus.flush_valid_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_spm", bus.spm_size_o, 32'h0001_0000);
    check("rst_async_busy", bus.busy_o, 1'b0);
    check("rst_async_flush", bus.flush_valid_o, 1'b0);
    check("rst_async_gate", bus.gate_o, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    bus.flush_done_i = 1'b1;
    tick();
    bus.flush_done_i = 1'b0;
    check("late_done_busy", bus.busy_o, 1'b0);
    check("late_done_spm", bus.spm_size_o, 32'h0001_0000);
    tick();
    check("late_done_spm_stable", bus.spm_size_o, 32'h0001_0000);
    check("late_done_ready", bus.cfg_ready_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
